spi_byte_master: RTL and testbench

SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

---
 rtl/spi_byte_master.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_byte_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// ---------------------------------------------------------------------------
// SpiByteMaster (module spi_byte_master)
//
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0). Each byte handed over
// on a valid/ready handshake is shifted out MSB first on oMOSI. At the same
// time a byte is shifted in from iMISO. Several bytes can share one chip
// select frame: a byte without iTX_LAST leaves oCSn low and waits for the
// next byte. A byte with iTX_LAST closes the frame. It does this with a hold
// time (oCSn still low) and then a gap (oCSn high), each CLK_DIV cycles long.
//
// Parameters
//   CLK_DIV   oSCLK half-period in iCLK cycles (1..255)
//
// Ports
//   iCLK       system clock, everything on its rising edge
//   iRESETn    synchronous, active-low reset
//   iTX_DATA   byte to transmit, MSB first
//   iTX_VALID  iTX_DATA / iTX_LAST valid
//   iTX_LAST   this byte ends the chip-select frame
//   oTX_READY  a byte is accepted this cycle if iTX_VALID is high
//   oRX_DATA   last byte received on iMISO, held until the next oRX_VALID
//   oRX_VALID  one-cycle strobe, oRX_DATA freshly updated
//   oBUSY      high whenever the engine is not idle
//   oSCLK      SPI clock
//   oMOSI      SPI data out
//   iMISO      SPI data in, already synchronous to iCLK
//   oCSn       SPI chip select, active-low
// ---------------------------------------------------------------------------
module spi_byte_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       iCLK,
   input  logic       iRESETn,
   input  logic [7:0] iTX_DATA,
   input  logic       iTX_VALID,
   input  logic       iTX_LAST,
   output logic       oTX_READY,
   output logic [7:0] oRX_DATA,
   output logic       oRX_VALID,
   output logic       oBUSY,
   output logic       oSCLK,
   output logic       oMOSI,
   input  logic       iMISO,
   output logic       oCSn
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      WAIT,
      HOLD,
      GAP
   } stateT;

   localparam logic [7:0] LAST_PHASE = 8'(CLK_DIV - 1);

   stateT      state,       stateNext;
   logic [7:0] phaseCnt,    phaseNext;
   logic [2:0] bitCnt,      bitNext;
   logic [6:0] txShift,     txShiftNext;
   logic [6:0] rxShift,     rxShiftNext;
   logic       lastFlag,    lastNext;
   logic       csnNext;
   logic       sclkNext;
   logic       mosiNext;
   logic       readyNext;
   logic       busyNext;
   logic [7:0] rxDataNext;
   logic       rxValidNext;
   logic       accept;

   // A byte is taken only when the registered ready flag is already high.
   // Ready is low in the first cycle after reset even though the state is
   // IDLE, so a byte offered in that cycle is not taken.
   assign accept = iTX_VALID & oTX_READY;

   // State, counters, shift registers and every output are registered
   // here. Reset returns the block to an idle, deselected bus with ready
   // low. Ready comes back one cycle after reset is released.
   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         state     <= IDLE;
         phaseCnt  <= 8'd0;
         bitCnt    <= 3'd0;
         txShift   <= 7'd0;
         rxShift   <= 7'd0;
         lastFlag  <= 1'b0;
         oCSn      <= 1'b1;
         oSCLK     <= 1'b0;
         oMOSI     <= 1'b0;
         oTX_READY <= 1'b0;
         oBUSY     <= 1'b0;
         oRX_DATA  <= 8'h00;
         oRX_VALID <= 1'b0;
      end else begin
         state     <= stateNext;
         phaseCnt  <= phaseNext;
         bitCnt    <= bitNext;
         txShift   <= txShiftNext;
         rxShift   <= rxShiftNext;
         lastFlag  <= lastNext;
         oCSn      <= csnNext;
         oSCLK     <= sclkNext;
         oMOSI     <= mosiNext;
         oTX_READY <= readyNext;
         oBUSY     <= busyNext;
         oRX_DATA  <= rxDataNext;
         oRX_VALID <= rxValidNext;
      end
   end

   // Next-state and next-output logic. The outputs are registered, so each
   // value computed here shows up in the cycle after the edge that takes
   // the decision. For example, oCSn falls in the first cycle after the
   // accept edge. phaseCnt counts the iCLK cycles inside one oSCLK half
   // period, or inside the HOLD and GAP intervals. oMOSI always carries the
   // bit being sent. txShift holds the bits still to send. rxShift gathers
   // the bits received so far.
   always_comb begin
      stateNext   = state;
      phaseNext   = phaseCnt;
      bitNext     = bitCnt;
      txShiftNext = txShift;
      rxShiftNext = rxShift;
      lastNext    = lastFlag;
      csnNext     = oCSn;
      sclkNext    = oSCLK;
      mosiNext    = oMOSI;
      readyNext   = oTX_READY;
      rxDataNext  = oRX_DATA;
      rxValidNext = 1'b0;

      unique case (state)
         IDLE: begin
            csnNext   = 1'b1;
            sclkNext  = 1'b0;
            mosiNext  = 1'b0;
            readyNext = 1'b1;
            phaseNext = 8'd0;
            bitNext   = 3'd0;
            if (accept) begin
               stateNext   = SHIFT;
               csnNext     = 1'b0;
               readyNext   = 1'b0;
               bitNext     = 3'd7;
               mosiNext    = iTX_DATA[7];
               txShiftNext = iTX_DATA[6:0];
               lastNext    = iTX_LAST;
            end
         end

         SHIFT: begin
            if (phaseCnt == LAST_PHASE) begin
               phaseNext = 8'd0;
               if (!oSCLK) begin
                  sclkNext = 1'b1;
               end else begin
                  sclkNext    = 1'b0;
                  rxShiftNext = {rxShift[5:0], iMISO};
                  if (bitCnt == 3'd0) begin
                     rxDataNext  = {rxShift, iMISO};
                     rxValidNext = 1'b1;
                     if (lastFlag) begin
                        stateNext = HOLD;
                     end else begin
                        stateNext = WAIT;
                        readyNext = 1'b1;
                     end
                  end else begin
                     bitNext     = bitCnt - 3'd1;
                     mosiNext    = txShift[6];
                     txShiftNext = {txShift[5:0], 1'b0};
                  end
               end
            end else begin
               phaseNext = phaseCnt + 8'd1;
            end
         end

         WAIT: begin
            readyNext = 1'b1;
            if (accept) begin
               stateNext   = SHIFT;
               readyNext   = 1'b0;
               phaseNext   = 8'd0;
               bitNext     = 3'd7;
               mosiNext    = iTX_DATA[7];
               txShiftNext = iTX_DATA[6:0];
               lastNext    = iTX_LAST;
            end
         end

         HOLD: begin
            if (phaseCnt == LAST_PHASE) begin
               stateNext = GAP;
               phaseNext = 8'd0;
               csnNext   = 1'b1;
               mosiNext  = 1'b0;
            end else begin
               phaseNext = phaseCnt + 8'd1;
            end
         end

         GAP: begin
            if (phaseCnt == LAST_PHASE) begin
               stateNext = IDLE;
               phaseNext = 8'd0;
               readyNext = 1'b1;
            end else begin
               phaseNext = phaseCnt + 8'd1;
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase

      busyNext = (stateNext != IDLE);
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// ---------------------------------------------------------------------------
// TbSpiByteMaster (module tb_spi_byte_master)
//
// Self-checking bench for spi_byte_master. Instance A runs with CLK_DIV=2.
// Its iMISO can be looped back to oMOSI, tied to 1 or to 0, or driven from a
// pattern that advances on every falling oSCLK. Instance B runs with
// CLK_DIV=1 and has iMISO looped back; it is used for back-to-back bytes in
// one frame. Every received byte is checked against an expected value queued
// when its byte is driven.
// ---------------------------------------------------------------------------
module tb_spi_byte_master;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic [7:0] pattern;
      logic [7:0] expRx;
   } vecT;

   logic       clk = 1'b0;

   logic       resetnA = 1'b0;
   logic [7:0] txDataA = 8'h00;
   logic       txValidA = 1'b0;
   logic       txLastA = 1'b0;
   logic       readyA, rxValidA, busyA, sclkA, mosiA, csnA;
   logic [7:0] rxDataA;
   logic       misoA;

   logic       resetnB = 1'b0;
   logic [7:0] txDataB = 8'h00;
   logic       txValidB = 1'b0;
   logic       txLastB = 1'b0;
   logic       readyB, rxValidB, busyB, sclkB, mosiB, csnB;
   logic [7:0] rxDataB;

   logic [1:0] misoMode = 2'd0;
   logic [7:0] misoPattern = 8'h00;
   logic [7:0] patternShifted;
   int         fallCount = 0;
   int         baseFall = 0;

   logic [7:0] sbA[$];
   logic [7:0] sbB[$];
   int         rxCountA = 0;
   int         rxCountB = 0;
   int         assertCount = 0;
   int         failCount = 0;

   vecT        vecs[6];

   always #5 clk = ~clk;

   spi_byte_master #(.CLK_DIV(2)) dutA (
      .iCLK(clk), .iRESETn(resetnA),
      .iTX_DATA(txDataA), .iTX_VALID(txValidA), .iTX_LAST(txLastA),
      .oTX_READY(readyA), .oRX_DATA(rxDataA), .oRX_VALID(rxValidA),
      .oBUSY(busyA), .oSCLK(sclkA), .oMOSI(mosiA), .iMISO(misoA),
      .oCSn(csnA)
   );

   spi_byte_master #(.CLK_DIV(1)) dutB (
      .iCLK(clk), .iRESETn(resetnB),
      .iTX_DATA(txDataB), .iTX_VALID(txValidB), .iTX_LAST(txLastB),
      .oTX_READY(readyB), .oRX_DATA(rxDataB), .oRX_VALID(rxValidB),
      .oBUSY(busyB), .oSCLK(sclkB), .oMOSI(mosiB), .iMISO(mosiB),
      .oCSn(csnB)
   );

   // The pattern slave shows pattern bit 7 before the first rising oSCLK.
   // It moves on one bit after each falling oSCLK, the way a mode 0 slave
   // would.
   always @(negedge sclkA) fallCount <= fallCount + 1;

   always_comb begin
      patternShifted = misoPattern << (fallCount - baseFall);
      case (misoMode)
         2'd0:    misoA = mosiA;
         2'd1:    misoA = 1'b1;
         2'd2:    misoA = 1'b0;
         default: misoA = patternShifted[7];
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: timed out, got no event, expected one", name);
   endtask

   // Scoreboard monitors: each strobe pops the oldest expected byte.
   always @(negedge clk) begin
      if (rxValidA === 1'b1) begin
         rxCountA++;
         if (sbA.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL rxUnexpectedA: got 0x%0h, expected no strobe", rxDataA);
         end else begin
            checkOutput("rxDataA", {24'd0, rxDataA}, {24'd0, sbA.pop_front()});
         end
      end
      if (rxValidB === 1'b1) begin
         rxCountB++;
         if (sbB.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL rxUnexpectedB: got 0x%0h, expected no strobe", rxDataB);
         end else begin
            checkOutput("rxDataB", {24'd0, rxDataB}, {24'd0, sbB.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Wait for ready on A, then present one byte for exactly one accept edge.
   task automatic applyStimulus(input logic [7:0] data, input logic last,
                                input bit push, input logic [7:0] expRx);
      int n;
      n = 0;
      @(negedge clk);
      while (readyA !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (readyA !== 1'b1) reportTimeout("readyA");
      if (push) sbA.push_back(expRx);
      txDataA  = data;
      txLastA  = last;
      txValidA = 1'b1;
      @(posedge clk);
      #1 txValidA = 1'b0;
   endtask

   task automatic waitIdleA();
      int n;
      n = 0;
      @(negedge clk);
      while (!(readyA === 1'b1 && busyA === 1'b0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!(readyA === 1'b1 && busyA === 1'b0)) reportTimeout("idleA");
   endtask

   initial begin
      int firstLow, lastLow, highCount, pulses, rxCyc, firstReady;
      int mosiErrs, rxBefore, bad, readyCyc, csnHigh, rxv1, rxv2, secondAcc;
      logic prevSclk, csnAt35, busyAt36, busyAt37, csnAt35B, readyAt36B;
      logic [7:0] d;

      vecs[0] = '{8'hA5, 2'd0, 8'h00, 8'hA5};
      vecs[1] = '{8'h3C, 2'd0, 8'h00, 8'h3C};
      vecs[2] = '{8'h00, 2'd1, 8'h00, 8'hFF};
      vecs[3] = '{8'hFF, 2'd2, 8'h00, 8'h00};
      vecs[4] = '{8'h12, 2'd3, 8'h5A, 8'h5A};
      vecs[5] = '{8'hE7, 2'd0, 8'h00, 8'hE7};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("resetCsn",     {31'd0, csnA},     32'd1);
      checkOutput("resetSclk",    {31'd0, sclkA},    32'd0);
      checkOutput("resetMosi",    {31'd0, mosiA},    32'd0);
      checkOutput("resetReady",   {31'd0, readyA},   32'd0);
      checkOutput("resetRxValid", {31'd0, rxValidA}, 32'd0);
      checkOutput("resetRxData",  {24'd0, rxDataA},  32'd0);
      checkOutput("resetBusy",    {31'd0, busyA},    32'd0);
      @(posedge clk);
      #1 resetnA = 1'b1;
      resetnB = 1'b1;
      @(negedge clk);
      checkOutput("readyStillLow", {31'd0, readyA}, 32'd0);
      @(negedge clk);
      checkOutput("readyAfterReset", {31'd0, readyA}, 32'd1);

      // Cycle-accurate trace of one 0xA5 frame with loopback, CLK_DIV=2
      d = 8'hA5;
      misoMode = 2'd0;
      applyStimulus(d, 1'b1, 1'b1, d);
      firstLow = -1; lastLow = -1; highCount = 0; pulses = 0; rxCyc = -1;
      firstReady = -1; mosiErrs = 0; prevSclk = 1'b0;
      csnAt35 = 1'b0; busyAt36 = 1'b0; busyAt37 = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (csnA === 1'b0) begin
            if (firstLow < 0) firstLow = cyc;
            lastLow = cyc;
         end
         if (sclkA === 1'b1) begin
            highCount++;
            if (prevSclk === 1'b0) pulses++;
            if (pulses >= 1 && pulses <= 8 && mosiA !== d[8 - pulses]) mosiErrs++;
         end
         prevSclk = sclkA;
         if (rxValidA === 1'b1) rxCyc = cyc;
         if (readyA === 1'b1 && firstReady < 0) firstReady = cyc;
         if (cyc == 35) csnAt35 = csnA;
         if (cyc == 36) busyAt36 = busyA;
         if (cyc == 37) busyAt37 = busyA;
      end
      checkOutput("csnFirstLow",  firstLow,   32'd1);
      checkOutput("csnLastLow",   lastLow,    32'd34);
      checkOutput("csnHigh35",    {31'd0, csnAt35}, 32'd1);
      checkOutput("sclkPulses",   pulses,     32'd8);
      checkOutput("sclkHighCyc",  highCount,  32'd16);
      checkOutput("mosiBitErrs",  mosiErrs,   32'd0);
      checkOutput("rxValidCycle", rxCyc,      32'd33);
      checkOutput("readyCycle",   firstReady, 32'd37);
      checkOutput("busyGap",      {31'd0, busyAt36}, 32'd1);
      checkOutput("busyIdle",     {31'd0, busyAt37}, 32'd0);

      // Table of single-byte frames with different slave behaviours
      for (int i = 0; i < 6; i++) begin
         misoMode    = vecs[i].mode;
         misoPattern = vecs[i].pattern;
         baseFall    = fallCount;
         applyStimulus(vecs[i].data, 1'b1, 1'b1, vecs[i].expRx);
         waitIdleA();
      end
      misoMode = 2'd0;

      // Offer a byte through SHIFT, HOLD and GAP: taken only once ready
      applyStimulus(8'h96, 1'b1, 1'b1, 8'h96);
      txDataA = 8'h0F;
      txLastA = 1'b1;
      txValidA = 1'b1;
      rxBefore = rxCountA;
      readyCyc = -1;
      for (int cyc = 1; cyc <= 60 && readyCyc < 0; cyc++) begin
         @(negedge clk);
         if (readyA === 1'b1) readyCyc = cyc;
      end
      if (readyCyc < 0) reportTimeout("readyBlocked");
      checkOutput("blockedReadyCycle", readyCyc, 32'd37);
      checkOutput("blockedRxCount", rxCountA - rxBefore, 32'd1);
      sbA.push_back(8'h0F);
      @(posedge clk);
      #1 txValidA = 1'b0;
      waitIdleA();

      // Reset at cycle 10 of a byte aborts it without a strobe
      rxBefore = rxCountA;
      applyStimulus(8'h55, 1'b1, 1'b0, 8'h00);
      repeat (9) @(posedge clk);
      #1 resetnA = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abortCsn",    {31'd0, csnA},    32'd1);
      checkOutput("abortSclk",   {31'd0, sclkA},   32'd0);
      checkOutput("abortReady",  {31'd0, readyA},  32'd0);
      checkOutput("abortBusy",   {31'd0, busyA},   32'd0);
      checkOutput("abortRxData", {24'd0, rxDataA}, 32'd0);
      resetnA = 1'b1;
      @(negedge clk);
      checkOutput("abortReadyBack", {31'd0, readyA}, 32'd1);
      repeat (40) @(negedge clk);
      checkOutput("abortNoStrobe", rxCountA - rxBefore, 32'd0);
      applyStimulus(8'h81, 1'b1, 1'b1, 8'h81);
      waitIdleA();

      // Long WAIT between two bytes of one frame
      rxBefore = rxCountA;
      applyStimulus(8'h3C, 1'b0, 1'b1, 8'h3C);
      for (int n = 0; n < 200 && rxCountA == rxBefore; n++) @(negedge clk);
      if (rxCountA == rxBefore) reportTimeout("waitEntry");
      bad = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (csnA !== 1'b0 || sclkA !== 1'b0 || busyA !== 1'b1 ||
             readyA !== 1'b1 || mosiA !== 1'b0) bad++;
      end
      checkOutput("waitHeldBad", bad, 32'd0);
      applyStimulus(8'hC3, 1'b1, 1'b1, 8'hC3);
      waitIdleA();

      // CLK_DIV=1: two bytes in one frame with iTX_VALID held high
      @(negedge clk);
      if (readyB !== 1'b1) reportTimeout("readyB");
      sbB.push_back(8'h3C);
      sbB.push_back(8'hC3);
      txDataB = 8'h3C;
      txLastB = 1'b0;
      txValidB = 1'b1;
      @(posedge clk);
      #1 txDataB = 8'hC3;
      txLastB = 1'b1;
      csnHigh = 0; rxv1 = -1; rxv2 = -1; secondAcc = -1;
      csnAt35B = 1'b0; readyAt36B = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc <= 34 && csnB !== 1'b0) csnHigh++;
         if (cyc == 35) csnAt35B = csnB;
         if (cyc == 36) readyAt36B = readyB;
         if (rxValidB === 1'b1) begin
            if (rxv1 < 0) rxv1 = cyc;
            else rxv2 = cyc;
         end
         if (readyB === 1'b1 && txValidB === 1'b1 && secondAcc < 0) begin
            secondAcc = cyc + 1;
            @(posedge clk);
            #1 txValidB = 1'b0;
         end
      end
      checkOutput("b2bSecondAcceptEdge", secondAcc, 32'd18);
      checkOutput("b2bCsnLowFrame", csnHigh, 32'd0);
      checkOutput("b2bRxValid1", rxv1, 32'd17);
      checkOutput("b2bRxValid2", rxv2, 32'd34);
      checkOutput("b2bCsnHigh35", {31'd0, csnAt35B}, 32'd1);
      checkOutput("b2bReady36", {31'd0, readyAt36B}, 32'd1);

      repeat (5) @(negedge clk);
      checkOutput("scoreboardA", sbA.size(), 32'd0);
      checkOutput("scoreboardB", sbB.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
